// File: rtl/lfsr_checker.sv
// Serial PRBS checker for the x^16 Fibonacci LFSR stream (taps 15,12,5,0).
// Self-synchronises from the received bits, flywheels once locked, and tracks errors.
module lfsr_checker #(
  parameter int LOCK_CNT = 32,
  parameter int WINDOW   = 64,
  parameter int LOSS_ERR = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [7:0]       LOCK_CNT_C = 8'(LOCK_CNT);
  localparam logic [7:0]       WINDOW_C   = 8'(WINDOW);
  localparam logic [7:0]       LOSS_ERR_C = 8'(LOSS_ERR);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_e           state_q, state_d;
  logic [15:0]      r_q, r_d;
  logic [3:0]       fill_cnt_q, fill_cnt_d;
  logic [7:0]       match_cnt_q, match_cnt_d;
  logic [7:0]       win_cnt_q, win_cnt_d;
  logic [7:0]       win_err_q, win_err_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;

  logic       predict;
  logic       mismatch;
  logic [7:0] match_inc;
  logic [7:0] win_cnt_inc;
  logic [7:0] win_err_inc;

  assign predict     = r_q[15] ^ r_q[12] ^ r_q[5] ^ r_q[0];
  assign mismatch    = in_bit ^ predict;
  assign match_inc   = match_cnt_q + 8'd1;
  assign win_cnt_inc = win_cnt_q + 8'd1;
  assign win_err_inc = win_err_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    bit_count_d = bit_count_q;

    if (in_valid) begin
      case (state_q)
        ST_FILL: begin
          r_d = {r_q[14:0], in_bit};
          if (fill_cnt_q == 4'd15) begin
            state_d     = ST_VERIFY;
            fill_cnt_d  = 4'd0;
            match_cnt_d = 8'd0;
          end else begin
            fill_cnt_d = fill_cnt_q + 4'd1;
          end
        end

        ST_VERIFY: begin
          r_d = {r_q[14:0], in_bit};
          // An all-zero history trivially predicts zero, so it never earns credit.
          if (!mismatch && (r_q != 16'd0)) begin
            if (match_inc == LOCK_CNT_C) begin
              state_d     = ST_LOCKED;
              locked_d    = 1'b1;
              match_cnt_d = 8'd0;
              win_cnt_d   = 8'd0;
              win_err_d   = 8'd0;
            end else begin
              match_cnt_d = match_inc;
            end
          end else begin
            match_cnt_d = 8'd0;
          end
        end

        ST_LOCKED: begin
          // Flywheel: feed back the prediction so a corrupted bit is counted once.
          r_d = {r_q[14:0], predict};
          if (bit_count_q != CNT_MAX) begin
            bit_count_d = bit_count_q + CNT_ONE;
          end
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_count_q != CNT_MAX) begin
              err_count_d = err_count_q + CNT_ONE;
            end
          end

          if (mismatch && (win_err_inc == LOSS_ERR_C)) begin
            state_d     = ST_FILL;
            locked_d    = 1'b0;
            fill_cnt_d  = 4'd0;
            match_cnt_d = 8'd0;
          end else if (win_cnt_inc == WINDOW_C) begin
            win_cnt_d = 8'd0;
            win_err_d = 8'd0;
          end else begin
            win_cnt_d = win_cnt_inc;
            win_err_d = mismatch ? win_err_inc : win_err_q;
          end
        end

        default: begin
          state_d    = ST_FILL;
          locked_d   = 1'b0;
          fill_cnt_d = 4'd0;
        end
      endcase
    end

    if (clr_cnt) begin
      err_count_d = '0;
      bit_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_FILL;
      r_q         <= 16'd0;
      fill_cnt_q  <= 4'd0;
      match_cnt_q <= 8'd0;
      win_cnt_q   <= 8'd0;
      win_err_q   <= 8'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Table-driven bench for lfsr_checker: stream segments with hand-computed outcomes,
// plus a CNT_W=4 instance fed the same stimulus to exercise counter saturation.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked, err_pulse;
  logic [15:0] err_count, bit_count;
  logic        locked4, err_pulse4;
  logic [3:0]  err_count4, bit_count4;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count)
  );

  lfsr_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
    .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4), .bit_count(bit_count4)
  );

  // One row per stream segment; k is the 1-based accepted-bit index within the segment.
  typedef struct packed {
    bit gaps;       // random idle cycles between accepted bits
    bit zeros;      // send all-zero data instead of the generator
    int nbits;
    int e_first;    // first inverted bit
    int e_step;
    int e_num;
    int clr_at;     // clr_cnt pulsed with this bit (0 = never)
    int rise_at;    // locked expected to rise after this bit (0 = never)
    int fall_at;    // locked expected to fall after this bit (0 = never)
    int exp_err;
    int exp_bits;
    int exp_err4;
    int exp_bits4;
    bit exp_locked;
    int exp_pulses;
  } seg_t;

  localparam int NSEG = 11;
  seg_t        segs [NSEG];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] gen_q = 16'hACE1;
  logic        exp_lock = 1'b0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[12] ^ s[5] ^ s[0]};
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_seg(input int s);
    seg_t sg;
    int   lock_bad;
    int   pulse_bad;
    int   pulses;
    bit   is_err;
    bit   was_locked;
    bit   exp_p;
    logic b;
    sg        = segs[s];
    lock_bad  = 0;
    pulse_bad = 0;
    pulses    = 0;
    for (int k = 1; k <= sg.nbits; k++) begin
      if (sg.gaps) begin
        for (int j = 0; j < 8; j++) begin
          if ($urandom_range(1) == 0) break;
          @(negedge clk);
          in_valid = 1'b0;
          in_bit   = 1'($urandom_range(1));
          clr_cnt  = 1'b0;
          @(posedge clk);
          #1;
          if (err_pulse !== 1'b0 || err_pulse4 !== 1'b0) pulse_bad++;
          if (locked !== exp_lock) lock_bad++;
        end
      end
      is_err = (sg.e_num > 0) && (k >= sg.e_first) && ((k - sg.e_first) % sg.e_step == 0)
               && ((k - sg.e_first) / sg.e_step < sg.e_num);
      if (sg.zeros) begin
        b = 1'b0;
      end else begin
        b     = gen_q[15];
        gen_q = lfsr_step(gen_q);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = b ^ is_err;
      clr_cnt  = (k == sg.clr_at);
      @(posedge clk);
      #1;
      was_locked = exp_lock;
      if (k == sg.fall_at) exp_lock = 1'b0;
      if (k == sg.rise_at) exp_lock = 1'b1;
      exp_p = is_err && was_locked;
      if (locked !== exp_lock || locked4 !== exp_lock) lock_bad++;
      if (err_pulse !== exp_p || err_pulse4 !== exp_p) pulse_bad++;
      if (err_pulse === 1'b1) pulses++;
      if (k == sg.clr_at) begin
        check($sformatf("seg%0d clr err_count", s), err_count, 0);
        check($sformatf("seg%0d clr bit_count", s), bit_count, 0);
        check($sformatf("seg%0d clr err_pulse", s), err_pulse, 1);
        check($sformatf("seg%0d clr err_count4", s), err_count4, 0);
        check($sformatf("seg%0d clr bit_count4", s), bit_count4, 0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    check($sformatf("seg%0d lock_trace_bad_cycles", s), lock_bad, 0);
    check($sformatf("seg%0d pulse_trace_bad_cycles", s), pulse_bad, 0);
    check($sformatf("seg%0d err_pulse_count", s), pulses, sg.exp_pulses);
    check($sformatf("seg%0d locked", s), locked, sg.exp_locked);
    check($sformatf("seg%0d err_count", s), err_count, sg.exp_err);
    check($sformatf("seg%0d bit_count", s), bit_count, sg.exp_bits);
    check($sformatf("seg%0d err_count4", s), err_count4, sg.exp_err4);
    check($sformatf("seg%0d bit_count4", s), bit_count4, sg.exp_bits4);
    $display("seg %0d: %0d bits, locked=%0d err_count=%0d bit_count=%0d err4=%0d bits4=%0d pulses=%0d",
             s, sg.nbits, locked, err_count, bit_count, err_count4, bit_count4, pulses);
  endtask

  task automatic seg_row(input int s, input bit gaps, input bit zeros, input int nbits,
                         input int ef, input int es, input int en, input int clr,
                         input int rise, input int fall, input int e, input int bts,
                         input int e4, input int b4, input bit lk, input int p);
    segs[s] = '{gaps, zeros, nbits, ef, es, en, clr, rise, fall, e, bts, e4, b4, lk, p};
  endtask

  initial begin
    //       s gap zero  nbits  ef es en clr rise fall err  bits   e4 b4 lk pulses
    seg_row(0, 0, 0,  10000,  0, 1, 0,  0,  48,   0,  0,  9952,  0, 15, 1, 0);
    seg_row(1, 0, 0,    416,200, 1, 1,  0,   0,   0,  1, 10368,  1, 15, 1, 1);
    seg_row(2, 0, 0,     84,  1, 5, 8,  0,  84,  36,  9, 10404,  9, 15, 1, 8);
    seg_row(3, 0, 0,     64,  4, 5, 7,  0,   0,   0, 16, 10468, 15, 15, 1, 7);
    seg_row(4, 0, 0,     64, 34, 5, 7,  0,   0,   0, 23, 10532, 15, 15, 1, 7);
    seg_row(5, 0, 0,     64,  1, 5, 7,  0,   0,   0, 30, 10596, 15, 15, 1, 7);
    seg_row(6, 0, 0,     10,  5, 1, 1,  5,   0,   0,  0,     5,  0,  5, 1, 1);
    seg_row(7, 1, 0,     48,  0, 1, 0,  0,  48,   0,  0,     0,  0,  0, 1, 0);
    seg_row(8, 1, 0,     84,  1, 5, 8,  0,  84,  36,  8,    36,  8, 15, 1, 8);
    seg_row(9, 1, 0,    100, 50, 1, 1,  0,   0,   0,  9,   136,  9, 15, 1, 1);
    seg_row(10, 0, 1,  1000,  0, 1, 0,  0,   0,   0,  0,     0,  0,  0, 0, 0);

    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset locked", locked, 0);
    check("reset err_pulse", err_pulse, 0);
    check("reset err_count", err_count, 0);
    check("reset bit_count", bit_count, 0);
    check("reset err_count4", err_count4, 0);
    check("reset bit_count4", bit_count4, 0);
    @(negedge clk);
    resetn   = 1'b1;
    exp_lock = 1'b0;

    for (int s = 0; s <= 6; s++) run_seg(s);

    // Reset mid-lock, asserted between edges: outputs must clear without a clock.
    check("pre-reset locked", locked, 1);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("async locked", locked, 0);
    check("async err_pulse", err_pulse, 0);
    check("async err_count", err_count, 0);
    check("async bit_count", bit_count, 0);
    check("async bit_count4", bit_count4, 0);
    @(negedge clk);
    resetn   = 1'b1;
    exp_lock = 1'b0;

    for (int s = 7; s <= 9; s++) run_seg(s);

    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn   = 1'b1;
    exp_lock = 1'b0;
    run_seg(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial PRBS checker for the 16-bit Fibonacci LFSR stream (feedback taps 15, 12, 5, 0; shift toward MSB, new bit into bit 0). It sits at the receive end of a link. There it consumes the bit shifted out of the generator's MSB each cycle, self-synchronises to the sequence without knowing the seed, and flywheels once locked. While locked it counts and flags bit errors, and it declares loss of lock when the error density gets too high.

## Interface
- LOCK_CNT, 32: consecutive correct predictions required to declare lock (1..255)
- WINDOW, 64: size of the loss-of-lock window, in accepted bits (2..255)
- LOSS_ERR, 8: errors within one window that force loss of lock (1..WINDOW)
- CNT_W, 16: width of the statistics counters
- clk  in  1  sole clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  in_bit is sampled on this cycle
- in_bit  in  1  received stream bit (generator's lfsr_out[15])
- clr_cnt  in  1  synchronous clear of err_count and bit_count
- locked  out  1  checker is in LOCKED state
- err_pulse  out  1  one-cycle pulse per detected error
- err_count  out  CNT_W  saturating count of errors while locked
- bit_count  out  CNT_W  saturating count of bits checked while locked

## Operation
- History register r[15:0]: r[0] holds the newest bit and r[15] the oldest. Predicted bit p = r[15]^r[12]^r[5]^r[0].
- The block acts only on cycles with in_valid=1. With in_valid=0 all state holds and err_pulse=0.
- State FILL: shift in_bit into r[0] and increment fill_cnt. When the 16th bit is accepted, go to VERIFY with match_cnt=0.
- State VERIFY: compare in_bit with p, then shift in_bit into r.
  - Match with r nonzero: match_cnt+1.
  - Mismatch, or r==0: match_cnt=0 and stay in VERIFY. The all-zero lockup stream never locks.
  - When match_cnt reaches LOCK_CNT: go to LOCKED, clear win_cnt and win_err.
- State LOCKED (flywheel): compare in_bit with p, and shift p (not in_bit) into r. A single bit error therefore counts exactly once.
  - Every accepted bit: bit_count+1 and win_cnt+1.
  - On mismatch: err_pulse=1, err_count+1, win_err+1.
  - If win_err including the current error reaches LOSS_ERR: go to FILL with fill_cnt=0. The threshold check takes priority over the window rollover.
  - Otherwise, when win_cnt reaches WINDOW: clear win_cnt and win_err, stay in LOCKED.
- err_count and bit_count saturate at 2^CNT_W-1 and never wrap.
- clr_cnt=1 forces both counters to 0 on that edge. clr_cnt wins over a simultaneous increment, and err_pulse still fires.
- Counters keep their values across loss of lock. Only resetn or clr_cnt clears them.
- Values after resetn low: state FILL, r=0, fill_cnt=0, match_cnt=0, locked=0, err_pulse=0, err_count=0, bit_count=0.
- Reset asserted mid-operation returns everything to these values immediately, with no clock required.

## Timing
- All outputs are registered.
- err_pulse is high for exactly the cycle after the edge that sampled the erroneous bit.
- locked rises on the edge that accepts the LOCK_CNT-th consecutive match. It falls on the edge that accepts the LOSS_ERR-th error in a window.
- Minimum time from reset release to locked with continuous in_valid: 16 + LOCK_CNT accepted bits (48 at defaults).
- After loss of lock, relock takes at least 16 + LOCK_CNT further accepted bits.
- Throughput: one bit per clock. There is no backpressure.
- in_valid gaps of any length are transparent: timing counts accepted bits, not cycles.

## Test plan
- Reset, then a continuous clean stream from the generator seeded 16'hACE1 → locked=1 after exactly 48 accepted bits; err_count=0 and err_pulse never set over 10000 bits; bit_count=9952.
- Locked stream with bit 200 inverted once → a single err_pulse one cycle after that bit, err_count=1, locked stays 1 (no error multiplication).
- Locked stream with 8 errors spaced 5 bits apart inside one 64-bit window → locked falls on the 8th error; clean stream afterwards → relocks exactly 48 bits later; err_count=8.
- 7 errors in each of several consecutive windows → locked stays 1 throughout; err_count = 7 × number of windows.
- All-zero input for 1000 bits → locked never asserts. Stream with in_valid toggling randomly at 50% → lock after 48 accepted bits, identical error behaviour to the gap-free case.
- clr_cnt pulsed on an error cycle → counters read 0 next cycle with err_pulse=1. Reset asserted mid-lock → all outputs 0 asynchronously. Force err_count to saturate (CNT_W=4, 20 errors) → holds at 15.
